vga_timing_monitor: RTL and testbench
=====================================

Name: vga_timing_monitor

Overview:
Receive-side checker for the team's VGA/HDMI-style raster sources; sits on the pixel-clock domain at the output of a timing generator (e.g. the 2200x1125 colour-bar source). Measures horizontal/vertical total and sync widths from active-low hsync/vsync, declares lock after consecutive identical frames, and captures one pixel at a programmable raster coordinate so benches and on-board debug can check both timing and colour content.

Parameters:
CW, 13, width of all counters and measurement outputs
LOCK_FRAMES, 2, consecutive matching frames required to enter LOCKED (1..7)
H_TIMEOUT, 8191, clocks without an hsync falling edge before declaring no signal (<= 2^CW-1)
SAMPLE_X, 300, hcnt value at which the pixel is captured
SAMPLE_Y, 100, vcnt value at which the pixel is captured

Ports:
clk  in  1  pixel clock, same domain as the source
rst  in  1  asynchronous, active-high reset
hsync  in  1  active-low line sync
vsync  in  1  active-low frame sync
red  in  4  pixel red
green  in  4  pixel green
blue  in  4  pixel blue
h_total  out  CW  last measured clocks per line
h_sync_w  out  CW  last measured hsync low width, clocks
v_total  out  CW  last measured lines per frame
v_sync_w  out  CW  last measured vsync low width, lines
frame_start  out  1  one-cycle pulse on each vsync falling edge
locked  out  1  high in LOCKED state
no_signal  out  1  high in NOSIG state
sample_rgb  out  12  {red,green,blue} captured at (SAMPLE_X,SAMPLE_Y)
sample_valid  out  1  one-cycle pulse when sample_rgb updates

Behaviour:
- Reset (async, rst=1): all outputs 0 except no_signal=1; hs_d=vs_d=1; hcnt=vcnt=0; match_cnt=0; state NOSIG.
- hs_d/vs_d: hsync/vsync registered one clock. hs_fall = hs_d & ~hsync; hs_rise = ~hs_d & hsync; likewise vs_fall/vs_rise. Inputs are used unsynchronised (same clock).
- hcnt: on hs_fall, h_total <= hcnt+1, hcnt <= 0; otherwise hcnt <= hcnt+1, saturating at 2^CW-1. On hs_rise, h_sync_w <= hcnt.
- vcnt: on vs_fall, v_total <= vcnt+1, vcnt <= 0 (takes priority over hs_fall in the same cycle); else on hs_fall vcnt <= vcnt+1, saturating. On vs_rise, v_sync_w <= vcnt + (hs_fall ? 1 : 0).
- Reference source (sync low hcnt 0..43, period 2200; vsync low lines 0..4, 1125 lines; edges coincident at frame wrap) yields h_total=2200, h_sync_w=44, v_total=1125, v_sync_w=5.
- frame_start: registered pulse, high the cycle after vs_fall detection.
- Frame compare at each vs_fall, using values held after the previous vs_fall (prev_*) versus the values valid at this edge (new v_total, current h_total/h_sync_w/v_sync_w): match -> match_cnt <= min(match_cnt+1, LOCK_FRAMES); mismatch -> match_cnt <= 0. prev_* then updated.
- FSM:
  - NOSIG: any hs_fall -> ACQUIRE; match_cnt 0.
  - ACQUIRE: match_cnt reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: mismatch at a vs_fall -> ACQUIRE (locked drops the cycle after the mismatching vs_fall).
  - Any state: hcnt reaching H_TIMEOUT -> NOSIG; match_cnt <= 0; measurement registers hold last values.
  - locked = (state==LOCKED), no_signal = (state==NOSIG), both registered.
- First vs_fall after reset/NOSIG only loads prev_* and never counts as a match.
- Sample: cycle with hcnt==SAMPLE_X and vcnt==SAMPLE_Y and state!=NOSIG -> sample_rgb <= {red,green,blue}, sample_valid pulses next cycle. No sample while hcnt/vcnt saturated.
- Glitch handling: none beyond edge detection; a 1-clock sync pulse is a valid edge pair.

Test Plan:
- Reset: assert rst mid-frame -> all measurements 0, no_signal=1, locked=0 immediately (async); release, reference source -> no_signal=0 after first hsync fall.
- Nominal 2200x1125 source: after 3 vsync falls (LOCK_FRAMES=2) locked=1; h_total=2200, h_sync_w=44, v_total=1125, v_sync_w=5; frame_start pulses once per 2,475,000 clocks.
- Colour sample: colour-bar source -> sample_valid once per frame, sample_rgb=12'hFFF at (300,100); with SAMPLE_X=500,SAMPLE_Y=200 -> 12'h049.
- Timing change while LOCKED: switch line period to 2201 -> locked=0 after next vs_fall; re-locks after 2 further matching frames with h_total=2201.
- Signal loss: hold hsync=1 -> no_signal=1 exactly H_TIMEOUT clocks after last hs_fall, locked=0, measurements retain 2200/44/1125/5.
- Counter saturation: hsync held low 10000 clocks -> hcnt saturates at 8191, no wrap; following hs_rise gives h_sync_w=8191.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side raster checker on the pixel-clock domain.
// It measures line and frame totals and sync widths from the active-low
// hsync/vsync. It declares lock after LOCK_FRAMES consecutive identical
// frames and flags loss of signal when hsync falls stop arriving. It also
// captures one pixel at (SAMPLE_X, SAMPLE_Y) in raster-counter coordinates.
module vga_timing_monitor #(
  parameter int CW          = 13,
  parameter int LOCK_FRAMES = 2,
  parameter int H_TIMEOUT   = 8191,
  parameter int SAMPLE_X    = 300,
  parameter int SAMPLE_Y    = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [3:0]    red,
  input  logic [3:0]    green,
  input  logic [3:0]    blue,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_sync_w,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_sync_w,
  output logic          frame_start,
  output logic          locked,
  output logic          no_signal,
  output logic [11:0]   sample_rgb,
  output logic          sample_valid
);

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TIMEOUT_V = CW'(H_TIMEOUT);
  localparam logic [CW-1:0] SAMPLE_XV = CW'(SAMPLE_X);
  localparam logic [CW-1:0] SAMPLE_YV = CW'(SAMPLE_Y);
  localparam logic [2:0]    LOCK_N    = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_NOSIG   = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Counters stick at all-ones rather than wrapping, so a stalled sync never
  // aliases back onto a plausible measurement.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  state_t        state_q, state_d;
  logic          hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
  logic [CW-1:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
  logic [CW-1:0] prev_h_total_q, prev_h_total_d, prev_h_sync_w_q, prev_h_sync_w_d;
  logic [CW-1:0] prev_v_total_q, prev_v_total_d, prev_v_sync_w_q, prev_v_sync_w_d;
  logic          prev_valid_q, prev_valid_d;
  logic [2:0]    match_cnt_q, match_cnt_d;
  logic          frame_start_q, frame_start_d;
  logic          locked_q, locked_d, no_signal_q, no_signal_d;
  logic [11:0]   sample_rgb_q, sample_rgb_d;
  logic          sample_valid_q, sample_valid_d;

  logic          hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
  logic [CW-1:0] v_total_new_s;
  logic          sample_hit_s, timeout_s, frame_match_s, frame_miss_s;

  assign hs_fall_s     = hs_dly_q & ~hsync;
  assign hs_rise_s     = ~hs_dly_q & hsync;
  assign vs_fall_s     = vs_dly_q & ~vsync;
  assign vs_rise_s     = ~vs_dly_q & vsync;
  assign v_total_new_s = sat_inc(vcnt_q);

  // Raster counters, timing measurements and pixel capture.
  always_comb begin
    hs_dly_d       = hsync;
    vs_dly_d       = vsync;
    hcnt_d         = hcnt_q;
    vcnt_d         = vcnt_q;
    h_total_d      = h_total_q;
    h_sync_w_d     = h_sync_w_q;
    v_total_d      = v_total_q;
    v_sync_w_d     = v_sync_w_q;
    sample_rgb_d   = sample_rgb_q;
    sample_valid_d = 1'b0;
    sample_hit_s   = 1'b0;

    if (hs_fall_s) begin
      h_total_d = sat_inc(hcnt_q);
      hcnt_d    = CNT_ZERO;
    end else begin
      hcnt_d    = sat_inc(hcnt_q);
    end

    // The fall cycle itself is a low clock, so the width is hcnt + 1.
    if (hs_rise_s) begin
      h_sync_w_d = sat_inc(hcnt_q);
    end else begin
      h_sync_w_d = h_sync_w_q;
    end

    // A frame edge outranks the coincident line edge.
    if (vs_fall_s) begin
      v_total_d = v_total_new_s;
      vcnt_d    = CNT_ZERO;
    end else if (hs_fall_s) begin
      vcnt_d    = sat_inc(vcnt_q);
    end else begin
      vcnt_d    = vcnt_q;
    end

    // vsync normally rises on a line edge that has not yet bumped vcnt.
    if (vs_rise_s) begin
      v_sync_w_d = hs_fall_s ? sat_inc(vcnt_q) : vcnt_q;
    end else begin
      v_sync_w_d = v_sync_w_q;
    end

    sample_hit_s = (hcnt_q == SAMPLE_XV) && (vcnt_q == SAMPLE_YV) &&
                   (hcnt_q != CNT_MAX) && (vcnt_q != CNT_MAX) &&
                   (state_q != ST_NOSIG);
    if (sample_hit_s) begin
      sample_rgb_d   = {red, green, blue};
      sample_valid_d = 1'b1;
    end else begin
      sample_rgb_d   = sample_rgb_q;
      sample_valid_d = 1'b0;
    end
  end

  // Frame-to-frame comparison, lock counting and the lock state machine.
  always_comb begin
    prev_h_total_d  = prev_h_total_q;
    prev_h_sync_w_d = prev_h_sync_w_q;
    prev_v_total_d  = prev_v_total_q;
    prev_v_sync_w_d = prev_v_sync_w_q;
    prev_valid_d    = prev_valid_q;
    match_cnt_d     = match_cnt_q;
    state_d         = state_q;
    frame_start_d   = vs_fall_s;
    timeout_s       = (hcnt_d == TIMEOUT_V);

    frame_match_s = prev_valid_q &&
                    (prev_h_total_q  == h_total_q) &&
                    (prev_h_sync_w_q == h_sync_w_q) &&
                    (prev_v_total_q  == v_total_new_s) &&
                    (prev_v_sync_w_q == v_sync_w_q);
    frame_miss_s  = vs_fall_s && prev_valid_q && !frame_match_s;

    if (vs_fall_s) begin
      prev_h_total_d  = h_total_q;
      prev_h_sync_w_d = h_sync_w_q;
      prev_v_total_d  = v_total_new_s;
      prev_v_sync_w_d = v_sync_w_q;
      prev_valid_d    = 1'b1;
    end else begin
      prev_valid_d    = prev_valid_q;
    end

    // A vs_fall seen while still in NOSIG only primes prev_*.
    if (state_q == ST_NOSIG) begin
      match_cnt_d = 3'd0;
    end else if (vs_fall_s && prev_valid_q) begin
      if (frame_match_s) begin
        match_cnt_d = (match_cnt_q >= LOCK_N) ? LOCK_N : match_cnt_q + 3'd1;
      end else begin
        match_cnt_d = 3'd0;
      end
    end else begin
      match_cnt_d = match_cnt_q;
    end

    case (state_q)
      ST_NOSIG:   state_d = hs_fall_s ? ST_ACQUIRE : ST_NOSIG;
      ST_ACQUIRE: state_d = (match_cnt_d == LOCK_N) ? ST_LOCKED : ST_ACQUIRE;
      ST_LOCKED:  state_d = frame_miss_s ? ST_ACQUIRE : ST_LOCKED;
      default:    state_d = ST_NOSIG;
    endcase

    // Timeout wins over everything; measurements are left untouched.
    if (timeout_s) begin
      state_d      = ST_NOSIG;
      match_cnt_d  = 3'd0;
      prev_valid_d = 1'b0;
    end else begin
      state_d      = state_d;
    end

    locked_d    = (state_d == ST_LOCKED);
    no_signal_d = (state_d == ST_NOSIG);
  end

  // State register for every flop in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_NOSIG;
      hs_dly_q        <= 1'b1;
      vs_dly_q        <= 1'b1;
      hcnt_q          <= CNT_ZERO;
      vcnt_q          <= CNT_ZERO;
      h_total_q       <= CNT_ZERO;
      h_sync_w_q      <= CNT_ZERO;
      v_total_q       <= CNT_ZERO;
      v_sync_w_q      <= CNT_ZERO;
      prev_h_total_q  <= CNT_ZERO;
      prev_h_sync_w_q <= CNT_ZERO;
      prev_v_total_q  <= CNT_ZERO;
      prev_v_sync_w_q <= CNT_ZERO;
      prev_valid_q    <= 1'b0;
      match_cnt_q     <= 3'd0;
      frame_start_q   <= 1'b0;
      locked_q        <= 1'b0;
      no_signal_q     <= 1'b1;
      sample_rgb_q    <= 12'h000;
      sample_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      hs_dly_q        <= hs_dly_d;
      vs_dly_q        <= vs_dly_d;
      hcnt_q          <= hcnt_d;
      vcnt_q          <= vcnt_d;
      h_total_q       <= h_total_d;
      h_sync_w_q      <= h_sync_w_d;
      v_total_q       <= v_total_d;
      v_sync_w_q      <= v_sync_w_d;
      prev_h_total_q  <= prev_h_total_d;
      prev_h_sync_w_q <= prev_h_sync_w_d;
      prev_v_total_q  <= prev_v_total_d;
      prev_v_sync_w_q <= prev_v_sync_w_d;
      prev_valid_q    <= prev_valid_d;
      match_cnt_q     <= match_cnt_d;
      frame_start_q   <= frame_start_d;
      locked_q        <= locked_d;
      no_signal_q     <= no_signal_d;
      sample_rgb_q    <= sample_rgb_d;
      sample_valid_q  <= sample_valid_d;
    end
  end

  assign h_total      = h_total_q;
  assign h_sync_w     = h_sync_w_q;
  assign v_total      = v_total_q;
  assign v_sync_w     = v_sync_w_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign no_signal    = no_signal_q;
  assign sample_rgb   = sample_rgb_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor. It uses a scaled raster of 64
// clocks x 10 lines, with hsync low for 6 clocks and vsync low for 2 lines,
// so that full lock sequences fit in a short run.
module tb_vga_timing_monitor;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst, hsync, vsync;
  logic [3:0]    red, green, blue;
  logic [CW-1:0] h_total, h_sync_w, v_total, v_sync_w;
  logic          frame_start, locked, no_signal, sample_valid;
  logic [11:0]   sample_rgb;

  int n_checks = 0;
  int n_pass   = 0;

  // Raster source state: mode 0 = running, 1 = syncs idle high, 2 = hsync held low
  int src_x = 0, src_y = 0, hp = 64, hsw = 6, vl = 10, vsw = 2, src_mode = 1;

  vga_timing_monitor #(.CW(CW), .LOCK_FRAMES(2), .H_TIMEOUT(500),
                       .SAMPLE_X(30), .SAMPLE_Y(5)) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
    .frame_start(frame_start), .locked(locked), .no_signal(no_signal),
    .sample_rgb(sample_rgb), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // Drive one source cycle, then wait past the rising edge that consumes it.
  task automatic drive_cycle();
    logic [12:0] xb, yb;
    xb = 13'(src_x);
    yb = 13'(src_y);
    if (src_mode == 0) begin
      hsync = (src_x < hsw) ? 1'b0 : 1'b1;
      vsync = (src_y < vsw) ? 1'b0 : 1'b1;
      red   = xb[7:4];
      green = yb[3:0];
      blue  = ~xb[7:4];
      if (src_x == hp - 1) begin
        src_x = 0;
        src_y = (src_y == vl - 1) ? 0 : src_y + 1;
      end else begin
        src_x = src_x + 1;
      end
    end else if (src_mode == 1) begin
      hsync = 1'b1;
      vsync = 1'b1;
    end else begin
      hsync = 1'b0;
      vsync = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_clocks(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  // Run until the next cycle to drive is (tx, ty); ty < 0 matches any line.
  task automatic run_until(input int tx, input int ty, input int maxc, input string nm);
    int k;
    k = 0;
    while (!(src_x == tx && (ty < 0 || src_y == ty)) && k < maxc) begin
      drive_cycle();
      k++;
    end
    n_checks++;
    if (!(src_x == tx && (ty < 0 || src_y == ty)))
      $display("FAIL %s: source position (%0d,%0d) not reached in %0d clocks", nm, tx, ty, maxc);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; red = 4'h0; green = 4'h0; blue = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (h_total !== 13'd0) $display("FAIL rst_h_total: got %0d want 0", h_total); else n_pass++;
    n_checks++; if (v_total !== 13'd0) $display("FAIL rst_v_total: got %0d want 0", v_total); else n_pass++;
    n_checks++; if (no_signal !== 1'b1) $display("FAIL rst_no_signal: got %b want 1", no_signal); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %b want 0", locked); else n_pass++;
    n_checks++; if (sample_rgb !== 12'h000 || sample_valid !== 1'b0)
      $display("FAIL rst_sample: got %h/%b want 000/0", sample_rgb, sample_valid); else n_pass++;
    rst = 1'b0;
  endtask

  // Lock needs four vsync falls from a frame-aligned start. Fall 1 primes
  // with a near-empty frame (v_total 1, widths 0), and fall 2 mismatches
  // against that. Falls 3 and 4 are the two matches.
  task automatic test_lock(input string tag);
    src_x = 0; src_y = 0; hp = 64; src_mode = 0;
    run_clocks(1);
    n_checks++; if (no_signal !== 1'b0) $display("FAIL %s_no_signal_after_fall: got %b want 0", tag, no_signal); else n_pass++;
    n_checks++; if (frame_start !== 1'b1) $display("FAIL %s_frame_start_pulse: got %b want 1", tag, frame_start); else n_pass++;
    run_clocks(1);
    n_checks++; if (frame_start !== 1'b0) $display("FAIL %s_frame_start_width: got %b want 0", tag, frame_start); else n_pass++;
    run_clocks(1918);
    n_checks++; if (locked !== 1'b0) $display("FAIL %s_locked_early: got %b want 0", tag, locked); else n_pass++;
    run_clocks(1);
    n_checks++; if (locked !== 1'b1) $display("FAIL %s_locked: got %b want 1", tag, locked); else n_pass++;
    n_checks++; if (h_total !== 13'd64 || h_sync_w !== 13'd6)
      $display("FAIL %s_h_meas: got %0d/%0d want 64/6", tag, h_total, h_sync_w); else n_pass++;
    n_checks++; if (v_total !== 13'd10 || v_sync_w !== 13'd2)
      $display("FAIL %s_v_meas: got %0d/%0d want 10/2", tag, v_total, v_sync_w); else n_pass++;
  endtask

  // Sample point hcnt=30, vcnt=5 sits in bar x[7:4]=1 of line 5, giving rgb 1,5,E.
  task automatic test_sample();
    int sv_cnt, fs_cnt;
    sv_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 640; i++) begin
      drive_cycle();
      if (sample_valid === 1'b1) sv_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    n_checks++; if (sv_cnt != 1) $display("FAIL sample_valid_per_frame: got %0d want 1", sv_cnt); else n_pass++;
    n_checks++; if (fs_cnt != 1) $display("FAIL frame_start_per_frame: got %0d want 1", fs_cnt); else n_pass++;
    n_checks++; if (sample_rgb !== 12'h15E) $display("FAIL sample_rgb: got %h want 15E", sample_rgb); else n_pass++;
  endtask

  // Line period 64 -> 65 from a frame start; frames are now 650 clocks.
  task automatic test_timing_change();
    run_until(0, 0, 1000, "tc_align");
    hp = 65;
    run_clocks(650);
    n_checks++; if (locked !== 1'b1) $display("FAIL tc_hold_lock: got %b want 1", locked); else n_pass++;
    run_clocks(1);
    n_checks++; if (locked !== 1'b0) $display("FAIL tc_unlock: got %b want 0", locked); else n_pass++;
    n_checks++; if (h_total !== 13'd65) $display("FAIL tc_h_total: got %0d want 65", h_total); else n_pass++;
    run_clocks(1299);
    n_checks++; if (locked !== 1'b0) $display("FAIL tc_relock_early: got %b want 0", locked); else n_pass++;
    run_clocks(1);
    n_checks++; if (locked !== 1'b1) $display("FAIL tc_relock: got %b want 1", locked); else n_pass++;
  endtask

  // Stop after the line-3 hsync pulse so no edges disturb the measurements.
  task automatic test_signal_loss();
    run_until(7, 3, 1000, "loss_align");
    src_mode = 1;
    run_clocks(493);
    n_checks++; if (no_signal !== 1'b0 || locked !== 1'b1)
      $display("FAIL loss_early: got ns=%b lk=%b want 0/1", no_signal, locked); else n_pass++;
    run_clocks(1);
    n_checks++; if (no_signal !== 1'b1 || locked !== 1'b0)
      $display("FAIL loss_timeout: got ns=%b lk=%b want 1/0", no_signal, locked); else n_pass++;
    n_checks++; if (h_total !== 13'd65 || h_sync_w !== 13'd6 || v_total !== 13'd10 || v_sync_w !== 13'd2)
      $display("FAIL loss_retain: got %0d/%0d/%0d/%0d want 65/6/10/2", h_total, h_sync_w, v_total, v_sync_w); else n_pass++;
  endtask

  task automatic test_saturation();
    src_mode = 2;
    run_clocks(10000);
    n_checks++; if (no_signal !== 1'b1) $display("FAIL sat_no_signal: got %b want 1", no_signal); else n_pass++;
    src_mode = 1;
    run_clocks(1);
    n_checks++; if (h_sync_w !== 13'd8191) $display("FAIL sat_h_sync_w: got %0d want 8191", h_sync_w); else n_pass++;
    src_mode = 2;
    run_clocks(1);
    n_checks++; if (h_total !== 13'd8191) $display("FAIL sat_h_total: got %0d want 8191", h_total); else n_pass++;
    n_checks++; if (no_signal !== 1'b0) $display("FAIL sat_reacquire: got %b want 0", no_signal); else n_pass++;
    src_mode = 1;
    run_clocks(1);
    n_checks++; if (h_sync_w !== 13'd1) $display("FAIL one_clock_pulse_w: got %0d want 1", h_sync_w); else n_pass++;
    n_checks++; if (v_total !== 13'd10) $display("FAIL sat_v_total_retain: got %0d want 10", v_total); else n_pass++;
  endtask

  // Mid-frame asynchronous reset is visible before any clock edge.
  task automatic test_async_reset();
    test_lock("relock");
    run_clocks(300);
    rst = 1'b1;
    #1;
    n_checks++; if (h_total !== 13'd0 || h_sync_w !== 13'd0 || v_total !== 13'd0 || v_sync_w !== 13'd0)
      $display("FAIL arst_meas: got %0d/%0d/%0d/%0d want 0/0/0/0", h_total, h_sync_w, v_total, v_sync_w); else n_pass++;
    n_checks++; if (no_signal !== 1'b1 || locked !== 1'b0)
      $display("FAIL arst_state: got ns=%b lk=%b want 1/0", no_signal, locked); else n_pass++;
    #2;
    rst = 1'b0;
    run_until(0, -1, 100, "arst_align");
    n_checks++; if (no_signal !== 1'b1) $display("FAIL arst_wait_fall: got %b want 1", no_signal); else n_pass++;
    run_clocks(1);
    n_checks++; if (no_signal !== 1'b0) $display("FAIL arst_reacquire: got %b want 0", no_signal); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock("lock");
    test_sample();
    test_timing_change();
    test_signal_loss();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
